// File: rtl/ipg_tx_frame_fifo_if.sv
// AXI-stream bundle used on both sides of the TX frame FIFO.
// The master modport drives the beat; the slave modport drives tready.
interface ipg_tx_frame_fifo_if #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/ipg_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: only committed frames reach the MAC, overflowing frames are dropped whole.
// Optional feature macro: IPG_TX_FIFO_DROP_BAD_EN (discard frames flagged bad by tuser on tlast).
module ipg_tx_frame_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int DEPTH_LOG2 = 9,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                   tx_clk,
   input  logic                   tx_rst,
   ipg_tx_frame_fifo_if.slave     s_axis,
   ipg_tx_frame_fifo_if.master    m_axis,
   output logic [DEPTH_LOG2:0]    occupancy,
   output logic                   drop_pulse,
   output logic                   good_pulse,
   output logic [CNT_WIDTH-1:0]   drop_count,
   output logic [CNT_WIDTH-1:0]   good_count
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int MW    = DATA_WIDTH + KEEP_WIDTH + 2;
   localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
   localparam logic [PW-1:0]        PTR_DEPTH = PW'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

   typedef enum logic [0:0] {ST_WRITE = 1'b0, ST_DROP = 1'b1} wr_state_e;

   wr_state_e              wr_state_q, wr_state_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          commit_ptr_q, commit_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic                   s_ready_q, s_ready_d;
   logic                   s1_valid_q, s1_valid_d;
   logic                   m_valid_q, m_valid_d;
   logic [MW-1:0]          m_beat_q, m_beat_d;
   logic [PW-1:0]          occ_q, occ_d;
   logic                   drop_pulse_q, drop_pulse_d;
   logic                   good_pulse_q, good_pulse_d;
   logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CNT_WIDTH-1:0]   good_cnt_q, good_cnt_d;

   logic [MW-1:0]          mem_q [DEPTH];
   logic [MW-1:0]          rd_data_q;

   logic                   beat_s;
   logic                   full_s;
   logic                   mem_we_s;
   logic                   frame_bad_s;
   logic [MW-1:0]          wr_beat_s;
   logic                   out_take_s;
   logic                   s2_load_s;
   logic                   s1_load_s;

`ifdef IPG_TX_FIFO_DROP_BAD_EN
   assign frame_bad_s = s_axis.tuser;
   assign wr_beat_s   = {1'b0, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
`else
   assign frame_bad_s = 1'b0;
   assign wr_beat_s   = {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
`endif

   assign beat_s = s_axis.tvalid & s_ready_q;
   assign full_s = (wr_ptr_q - rd_ptr_q) == PTR_DEPTH;

   // Write-side frame FSM: store, commit on good tlast, roll back to commit_ptr on any drop.
   always_comb begin
      wr_state_d   = wr_state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      mem_we_s     = 1'b0;
      drop_pulse_d = 1'b0;
      good_pulse_d = 1'b0;
      case (wr_state_q)
         ST_WRITE: begin
            if (beat_s) begin
               if (!full_s) begin
                  mem_we_s = 1'b1;
                  if (s_axis.tlast && frame_bad_s) begin
                     wr_ptr_d     = commit_ptr_q;
                     drop_pulse_d = 1'b1;
                  end else if (s_axis.tlast) begin
                     wr_ptr_d     = wr_ptr_q + PTR_ONE;
                     commit_ptr_d = wr_ptr_q + PTR_ONE;
                     good_pulse_d = 1'b1;
                  end else begin
                     wr_ptr_d = wr_ptr_q + PTR_ONE;
                  end
               end else begin
                  wr_ptr_d = commit_ptr_q;
                  if (s_axis.tlast) begin
                     drop_pulse_d = 1'b1;
                  end else begin
                     wr_state_d = ST_DROP;
                  end
               end
            end else begin
               wr_state_d = ST_WRITE;
            end
         end
         ST_DROP: begin
            wr_ptr_d = commit_ptr_q;
            if (beat_s && s_axis.tlast) begin
               drop_pulse_d = 1'b1;
               wr_state_d   = ST_WRITE;
            end else begin
               wr_state_d = ST_DROP;
            end
         end
         default: begin
            wr_state_d = ST_WRITE;
            wr_ptr_d   = commit_ptr_q;
         end
      endcase
   end

   // Two-stage read prefetch: a stage loads when empty or when its successor is consumed.
   always_comb begin
      out_take_s = m_valid_q & m_axis.tready;
      s2_load_s  = s1_valid_q & (~m_valid_q | out_take_s);
      s1_load_s  = (rd_ptr_q != commit_ptr_q) & (~s1_valid_q | s2_load_s);
      rd_ptr_d   = rd_ptr_q;
      s1_valid_d = s1_valid_q;
      m_valid_d  = m_valid_q;
      m_beat_d   = m_beat_q;
      if (s1_load_s) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         s1_valid_d = 1'b1;
      end else if (s2_load_s) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end
      if (s2_load_s) begin
         m_valid_d = 1'b1;
         m_beat_d  = rd_data_q;
      end else if (out_take_s) begin
         m_valid_d = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end
   end

   // Occupancy counts beats still owed to the MAC, including the two prefetch stages.
   always_comb begin
      s_ready_d = 1'b1;
      occ_d     = (wr_ptr_d - rd_ptr_d) + {{(PW-1){1'b0}}, s1_valid_d} + {{(PW-1){1'b0}}, m_valid_d};
      if (drop_pulse_d && (drop_cnt_q != CNT_MAX)) begin
         drop_cnt_d = drop_cnt_q + CNT_ONE;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
      if (good_pulse_d && (good_cnt_q != CNT_MAX)) begin
         good_cnt_d = good_cnt_q + CNT_ONE;
      end else begin
         good_cnt_d = good_cnt_q;
      end
   end

   // Control and output registers.
   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         wr_state_q   <= ST_WRITE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         s_ready_q    <= 1'b0;
         s1_valid_q   <= 1'b0;
         m_valid_q    <= 1'b0;
         m_beat_q     <= '0;
         occ_q        <= '0;
         drop_pulse_q <= 1'b0;
         good_pulse_q <= 1'b0;
         drop_cnt_q   <= '0;
         good_cnt_q   <= '0;
      end else begin
         wr_state_q   <= wr_state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         s_ready_q    <= s_ready_d;
         s1_valid_q   <= s1_valid_d;
         m_valid_q    <= m_valid_d;
         m_beat_q     <= m_beat_d;
         occ_q        <= occ_d;
         drop_pulse_q <= drop_pulse_d;
         good_pulse_q <= good_pulse_d;
         drop_cnt_q   <= drop_cnt_d;
         good_cnt_q   <= good_cnt_d;
      end
   end

   // Frame buffer: one synchronous write port, one synchronous read port into the prefetch stage.
   always_ff @(posedge tx_clk) begin
      if (mem_we_s) begin
         mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_beat_s;
      end
      if (s1_load_s) begin
         rd_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
      end
   end

   assign s_axis.tready = s_ready_q;
   assign m_axis.tvalid = m_valid_q;
   assign m_axis.tdata  = m_beat_q[DATA_WIDTH-1:0];
   assign m_axis.tkeep  = m_beat_q[DATA_WIDTH +: KEEP_WIDTH];
   assign m_axis.tlast  = m_beat_q[DATA_WIDTH + KEEP_WIDTH];
`ifdef IPG_TX_FIFO_DROP_BAD_EN
   assign m_axis.tuser  = 1'b0;
`else
   assign m_axis.tuser  = m_beat_q[MW-1];
`endif
   assign occupancy     = occ_q;
   assign drop_pulse    = drop_pulse_q;
   assign good_pulse    = good_pulse_q;
   assign drop_count    = drop_cnt_q;
   assign good_count    = good_cnt_q;
endmodule

// File: tb/tb_ipg_tx_frame_fifo.sv
// Self-checking bench for ipg_tx_frame_fifo: randomized frames against a frame-level scoreboard.
module tb_ipg_tx_frame_fifo;
   localparam int DW = 64;
   localparam int KW = 8;
   localparam int DL = 9;
   localparam int CW = 16;
`ifdef IPG_TX_FIFO_DROP_BAD_EN
   localparam bit DROP_BAD = 1'b1;
`else
   localparam bit DROP_BAD = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic          u;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [DL:0]   occupancy;
   logic          drop_pulse;
   logic          good_pulse;
   logic [CW-1:0] drop_count;
   logic [CW-1:0] good_count;

   ipg_tx_frame_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_if ();
   ipg_tx_frame_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_if ();

   ipg_tx_frame_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW)) dut (
      .tx_clk     (clk),
      .tx_rst     (rst),
      .s_axis     (s_if),
      .m_axis     (m_if),
      .occupancy  (occupancy),
      .drop_pulse (drop_pulse),
      .good_pulse (good_pulse),
      .drop_count (drop_count),
      .good_count (good_count)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    failures = 0;
   int    out_cnt = 0;
   int    mvalid_cycles = 0;
   int    sready_low = 0;
   int    drop_seen = 0;
   int    exp_good = 0;
   int    exp_drop = 0;
   beat_t exp_q[$];
   bit    mon_en = 1'b0;
   bit    rand_rdy = 1'b0;
   bit    prev_stall = 1'b0;
   beat_t prev_beat;
   beat_t cur_b;
   beat_t exp_b;

   // Output monitor: scoreboard every handshake, and hold-stability while stalled.
   always @(negedge clk) begin
      cur_b = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
      if (mon_en) begin
         if (prev_stall) begin
            checks++;
            if (m_if.tvalid !== 1'b1 || cur_b !== prev_beat) begin
               failures++;
               $display("FAIL stall_hold: got valid=%0b beat=%h, required valid=1 beat=%h", m_if.tvalid, cur_b, prev_beat);
            end
         end
         if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat: got beat=%h, required no beat", cur_b);
            end else begin
               exp_b = exp_q.pop_front();
               if (cur_b !== exp_b) begin
                  failures++;
                  $display("FAIL beat_content: got %h, required %h", cur_b, exp_b);
               end
            end
            out_cnt++;
         end
         prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
         prev_beat  = cur_b;
      end else begin
         prev_stall = 1'b0;
      end
      if (m_if.tvalid === 1'b1) mvalid_cycles++;
      if (s_if.tready !== 1'b1) sready_low++;
      if (drop_pulse === 1'b1) drop_seen++;
   end

   // Random MAC backpressure.
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         m_if.tready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no completion, required completion before time limit");
      $fatal(1, "watchdog");
   end

   task automatic send_frame(input int len, input logic [KW-1:0] last_keep, input logic last_user,
                             input int gap_pct, input bit fits);
      beat_t fr[$];
      bit    commit;
      commit = fits && !(DROP_BAD && last_user);
      for (int i = 0; i < len; i++) begin
         beat_t b;
         logic  u;
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            @(posedge clk); #1;
            s_if.tvalid = 1'b0;
         end
         b.d = {$urandom(), $urandom()};
         b.l = (i == len - 1);
         b.k = b.l ? last_keep : {KW{1'b1}};
         u   = b.l ? last_user : 1'($urandom_range(0, 1));
         b.u = DROP_BAD ? 1'b0 : u;
         @(posedge clk); #1;
         s_if.tdata  = b.d;
         s_if.tkeep  = b.k;
         s_if.tlast  = b.l;
         s_if.tuser  = u;
         s_if.tvalid = 1'b1;
         fr.push_back(b);
      end
      @(posedge clk); #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      if (commit) begin
         foreach (fr[j]) exp_q.push_back(fr[j]);
         exp_good++;
      end else begin
         exp_drop++;
      end
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         if (exp_q.size() == 0 && m_if.tvalid === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
      m_if.tready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !== '0) begin
         failures++;
         $display("FAIL reset_m_axis: got valid=%0b data=%h keep=%h, required all zero", m_if.tvalid, m_if.tdata, m_if.tkeep);
      end
      checks++;
      if ({occupancy, drop_pulse, good_pulse, drop_count, good_count} !== '0) begin
         failures++;
         $display("FAIL reset_status: got occ=%0d dc=%0d gc=%0d, required 0", occupancy, drop_count, good_count);
      end
      checks++;
      if (s_if.tready !== 1'b0) begin
         failures++;
         $display("FAIL reset_tready: got %b, required 0", s_if.tready);
      end
      rst = 1'b0;
      @(posedge clk); #2;
      checks++;
      if (s_if.tready !== 1'b1) begin
         failures++;
         $display("FAIL tready_after_reset: got %b, required 1", s_if.tready);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_single_frame();
      int base;
      m_if.tready = 1'b1;
      send_frame(8, 8'h0F, 1'b0, 0, 1'b1);
      #1;
      base = out_cnt;
      checks++;
      if (m_if.tvalid !== 1'b0 || good_pulse !== 1'b1) begin
         failures++;
         $display("FAIL latency_e0: got valid=%b good_pulse=%b, required valid=0 good_pulse=1", m_if.tvalid, good_pulse);
      end
      @(posedge clk); #2;
      checks++;
      if (m_if.tvalid !== 1'b0) begin
         failures++;
         $display("FAIL latency_e1: got valid=%b, required 0", m_if.tvalid);
      end
      @(posedge clk); #2;
      checks++;
      if (m_if.tvalid !== 1'b1) begin
         failures++;
         $display("FAIL latency_e2: got valid=%b, required 1", m_if.tvalid);
      end
      repeat (8) @(posedge clk);
      #2;
      checks++;
      if (out_cnt - base != 8 || m_if.tvalid !== 1'b0) begin
         failures++;
         $display("FAIL single_burst: got beats=%0d valid=%b, required beats=8 valid=0", out_cnt - base, m_if.tvalid);
      end
      checks++;
      if (good_count !== CW'(exp_good) || occupancy !== '0) begin
         failures++;
         $display("FAIL single_counts: got gc=%0d occ=%0d, required gc=%0d occ=0", good_count, occupancy, exp_good);
      end
   endtask

   task automatic test_fill_burst();
      int base;
      m_if.tready = 1'b0;
      for (int f = 0; f < 64; f++) send_frame(4, KW'($urandom_range(1, 255)), 1'b0, 0, 1'b1);
      repeat (4) @(posedge clk);
      #2;
      checks++;
      if (occupancy !== 10'd256 || m_if.tvalid !== 1'b1 || good_count !== CW'(exp_good)) begin
         failures++;
         $display("FAIL fill_256: got occ=%0d valid=%b gc=%0d, required occ=256 valid=1 gc=%0d", occupancy, m_if.tvalid, good_count, exp_good);
      end
      @(posedge clk); #1;
      m_if.tready = 1'b1;
      base = out_cnt;
      repeat (256) @(posedge clk);
      #2;
      checks++;
      if (out_cnt - base != 256 || m_if.tvalid !== 1'b0 || occupancy !== '0) begin
         failures++;
         $display("FAIL burst_256: got beats=%0d valid=%b occ=%0d, required beats=256 valid=0 occ=0", out_cnt - base, m_if.tvalid, occupancy);
      end
   endtask

   task automatic test_oversize();
      int mv0, sr0, ds0;
      m_if.tready = 1'b0;
      mv0 = mvalid_cycles; sr0 = sready_low; ds0 = drop_seen;
      send_frame(600, 8'hFF, 1'b0, 0, 1'b0);
      #1;
      checks++;
      if (drop_pulse !== 1'b1) begin
         failures++;
         $display("FAIL oversize_pulse: got %b, required 1", drop_pulse);
      end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (drop_count !== CW'(exp_drop) || occupancy !== '0 || drop_seen - ds0 != 1) begin
         failures++;
         $display("FAIL oversize_drop: got dc=%0d occ=%0d pulses=%0d, required dc=%0d occ=0 pulses=1", drop_count, occupancy, drop_seen - ds0, exp_drop);
      end
      checks++;
      if (mvalid_cycles != mv0 || sready_low != sr0) begin
         failures++;
         $display("FAIL oversize_sides: got mvalid_cycles=%0d tready_low=%0d, required 0 and 0", mvalid_cycles - mv0, sready_low - sr0);
      end
   endtask

   task automatic test_overflow_window();
      bit ok;
      m_if.tready = 1'b0;
      for (int f = 0; f < 125; f++) send_frame(4, 8'hFF, 1'b0, 0, 1'b1);
      @(posedge clk); #2;
      checks++;
      if (occupancy !== 10'd500) begin
         failures++;
         $display("FAIL hold_500: got occ=%0d, required 500", occupancy);
      end
      send_frame(20, 8'h3F, 1'b0, 0, 1'b0);
      @(posedge clk); #2;
      checks++;
      if (drop_count !== CW'(exp_drop) || occupancy !== 10'd500 || good_count !== CW'(exp_good)) begin
         failures++;
         $display("FAIL overflow_20: got dc=%0d occ=%0d gc=%0d, required dc=%0d occ=500 gc=%0d", drop_count, occupancy, good_count, exp_drop, exp_good);
      end
      @(posedge clk); #1;
      m_if.tready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      m_if.tready = 1'b0;
      #1;
      checks++;
      if (occupancy !== 10'd480) begin
         failures++;
         $display("FAIL read_20: got occ=%0d, required 480", occupancy);
      end
      send_frame(4, 8'h01, 1'b0, 0, 1'b1);
      m_if.tready = 1'b1;
      wait_drain(1200, ok);
      checks++;
      if (!ok || occupancy !== '0 || good_count !== CW'(exp_good)) begin
         failures++;
         $display("FAIL after_overflow: got drained=%0b occ=%0d gc=%0d, required drained=1 occ=0 gc=%0d", ok, occupancy, good_count, exp_good);
      end
   endtask

   task automatic test_bad_frame();
      bit ok;
      m_if.tready = 1'b1;
      send_frame(3, 8'h07, 1'b1, 0, 1'b1);
      wait_drain(50, ok);
      checks++;
      if (!ok || drop_count !== CW'(exp_drop) || good_count !== CW'(exp_good)) begin
         failures++;
         $display("FAIL bad_frame: got drained=%0b dc=%0d gc=%0d, required drained=1 dc=%0d gc=%0d", ok, drop_count, good_count, exp_drop, exp_good);
      end
   endtask

   task automatic test_random();
      bit ok;
      rand_rdy = 1'b1;
      for (int f = 0; f < 40; f++) begin
         int waited = 0;
         while (occupancy > 10'd300 && waited < 2000) begin
            @(posedge clk); #2;
            waited++;
         end
         checks++;
         if (waited >= 2000) begin
            failures++;
            $display("FAIL random_backlog: got occ=%0d after 2000 cycles, required <= 300", occupancy);
         end
         send_frame($urandom_range(1, 12), KW'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 25, 1'b1);
      end
      @(posedge clk); #2;
      rand_rdy = 1'b0;
      @(posedge clk); #1;
      m_if.tready = 1'b1;
      wait_drain(2000, ok);
      checks++;
      if (!ok || good_count !== CW'(exp_good) || drop_count !== CW'(exp_drop) || occupancy !== '0) begin
         failures++;
         $display("FAIL random_totals: got drained=%0b gc=%0d dc=%0d occ=%0d, required drained=1 gc=%0d dc=%0d occ=0", ok, good_count, drop_count, occupancy, exp_good, exp_drop);
      end
   endtask

   task automatic test_reset_mid();
      int  base;
      int  n;
      bit  ok;
      m_if.tready = 1'b1;
      base = out_cnt;
      send_frame(10, 8'hFF, 1'b0, 0, 1'b1);
      n = 0;
      while (out_cnt - base < 4 && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      checks++;
      if (out_cnt - base != 4) begin
         failures++;
         $display("FAIL reset_mid_setup: got beats=%0d, required 4", out_cnt - base);
      end
      rst = 1'b1;
      mon_en = 1'b0;
      #1;
      checks++;
      if ({m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !== '0 || {drop_count, good_count, occupancy} !== '0) begin
         failures++;
         $display("FAIL reset_mid_clear: got valid=%b data=%h gc=%0d dc=%0d occ=%0d, required all zero", m_if.tvalid, m_if.tdata, good_count, drop_count, occupancy);
      end
      exp_q.delete();
      exp_good = 0;
      exp_drop = 0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk); #2;
      mon_en = 1'b1;
      send_frame(10, 8'h0F, 1'b0, 0, 1'b1);
      wait_drain(100, ok);
      checks++;
      if (!ok || good_count !== CW'(1) || occupancy !== '0) begin
         failures++;
         $display("FAIL reset_mid_next: got drained=%0b gc=%0d occ=%0d, required drained=1 gc=1 occ=0", ok, good_count, occupancy);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_fill_burst();
      test_oversize();
      test_overflow_window();
      test_bad_frame();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
